soda_controller: RTL and testbench

- Control FSM for the soda vending path. It sequences the accumulator datapath: it debounces coin insertions into single tot_ld pulses, clears the total with tot_clr, reads the tot_lt_s comparison back, and drives the dispense output.
- It also refunds abandoned credit after a timeout and keeps a saturating count of sodas sold.
- Sits between the coin sensor / dispenser hardware and the soda datapath.

---
 rtl/soda_controller.sv | 135 +++++++++++++
 tb/tb_soda_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soda_controller.sv
// Control FSM for the soda vending path: debounces coins into single load pulses,
// triggers a vend once the datapath reports enough credit, and refunds abandoned credit.
module soda_controller #(
  parameter int unsigned DISP_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             coin_in_i,
  input  logic             tot_lt_s_i,
  output logic             tot_ld_o,
  output logic             tot_clr_o,
  output logic             dispense_o,
  output logic             refund_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] vend_count_o
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_WAIT    = 3'd1,
    S_ADD     = 3'd2,
    S_RELEASE = 3'd3,
    S_DISP    = 3'd4,
    S_REFUND  = 3'd5
  } state_e;

  localparam logic [15:0]      TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [7:0]       DISP_LAST = 8'(DISP_CYCLES - 1);
  localparam logic [CNT_W-1:0] VEND_MAX  = '1;

  state_e           state_q, state_d;
  logic             have_credit_q, have_credit_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [7:0]       disp_cnt_q, disp_cnt_d;
  logic [CNT_W-1:0] vend_q, vend_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_INIT;
      have_credit_q <= 1'b0;
      tmo_q         <= '0;
      disp_cnt_q    <= '0;
      vend_q        <= '0;
    end else begin
      state_q       <= state_d;
      have_credit_q <= have_credit_d;
      tmo_q         <= tmo_d;
      disp_cnt_q    <= disp_cnt_d;
      vend_q        <= vend_d;
    end
  end

  // WAIT priority: vend beats a new coin, a coin beats the refund timer.
  always_comb begin
    state_d       = state_q;
    have_credit_d = have_credit_q;
    tmo_d         = tmo_q;
    disp_cnt_d    = disp_cnt_q;
    vend_d        = vend_q;
    case (state_q)
      S_INIT: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (have_credit_q && !tot_lt_s_i) begin
          state_d    = S_DISP;
          disp_cnt_d = '0;
          tmo_d      = '0;
          vend_d     = (vend_q == VEND_MAX) ? vend_q : vend_q + CNT_W'(1);
        end else if (coin_in_i) begin
          state_d = S_ADD;
          tmo_d   = '0;
        end else if (have_credit_q) begin
          if (tmo_q == TMO_LAST) begin
            state_d = S_REFUND;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end else begin
          tmo_d = '0;
        end
      end
      S_ADD: begin
        have_credit_d = 1'b1;
        state_d       = S_RELEASE;
      end
      S_RELEASE: begin
        if (!coin_in_i) begin
          state_d = S_WAIT;
        end
      end
      S_DISP: begin
        if (disp_cnt_q == DISP_LAST) begin
          have_credit_d = 1'b0;
          state_d       = S_INIT;
        end else begin
          disp_cnt_d = disp_cnt_q + 8'd1;
        end
      end
      S_REFUND: begin
        have_credit_d = 1'b0;
        tmo_d         = '0;
        state_d       = S_WAIT;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    tot_ld_o   = 1'b0;
    tot_clr_o  = 1'b0;
    dispense_o = 1'b0;
    refund_o   = 1'b0;
    busy_o     = 1'b1;
    case (state_q)
      S_INIT:   tot_clr_o  = 1'b1;
      S_WAIT:   busy_o     = 1'b0;
      S_ADD:    tot_ld_o   = 1'b1;
      S_DISP:   dispense_o = 1'b1;
      S_REFUND: begin
        refund_o  = 1'b1;
        tot_clr_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign vend_count_o = vend_q;

endmodule

// File: tb/tb_soda_controller.sv
// Self-checking bench for soda_controller: directed scenarios plus random traffic,
// compared cycle by cycle against a behavioural model of the vending rules.
module tb_soda_controller;

  localparam int DISP_CYCLES = 4;
  localparam int TIMEOUT     = 200;
  localparam int CNT_W       = 8;
  localparam int W           = 5 + CNT_W;
  localparam int VEND_MAX    = (1 << CNT_W) - 1;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n    = 1'b0;
  logic             coin_in  = 1'b0;
  logic             tot_lt_s = 1'b1;
  logic             tot_ld, tot_clr, dispense, refund, busy;
  logic [CNT_W-1:0] vend_count;

  soda_controller #(
    .DISP_CYCLES(DISP_CYCLES),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .coin_in_i   (coin_in),
    .tot_lt_s_i  (tot_lt_s),
    .tot_ld_o    (tot_ld),
    .tot_clr_o   (tot_clr),
    .dispense_o  (dispense),
    .refund_o    (refund),
    .busy_o      (busy),
    .vend_count_o(vend_count)
  );

  // Scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model: pending pulses and remaining-cycle counts rather than named states.
  bit m_clr = 0, m_ld = 0, m_hold = 0, m_refund = 0, m_credit = 0;
  int m_disp_left = 0, m_idle = 0, m_sold = 0;

  // Simple datapath stand-in that produces tot_lt_s from the coins actually loaded.
  int total = 0, price = 100, coin_val = 1;

  // Observation-side bookkeeping (DUT outputs only).
  int  cyc = 0, wait_start = 0, disp_run = 0, ld_seen = 0, refund_seen = 0;
  bit  run_cut = 0, prev_busy = 1;

  function automatic logic [W-1:0] m_outputs();
    logic             idle_now;
    logic [CNT_W-1:0] v;
    idle_now = !(m_clr || m_ld || m_hold || (m_disp_left > 0) || m_refund);
    v = (m_sold > VEND_MAX) ? CNT_W'(VEND_MAX) : CNT_W'(m_sold);
    return {m_ld, m_clr || m_refund, m_disp_left > 0, m_refund, !idle_now, v};
  endfunction

  task automatic model_advance(input bit r, input bit c, input bit lt);
    if (!r) begin
      m_clr = 1; m_ld = 0; m_hold = 0; m_refund = 0;
      m_disp_left = 0; m_credit = 0; m_idle = 0; m_sold = 0;
    end else if (m_refund) begin
      m_refund = 0; m_credit = 0; m_idle = 0;
    end else if (m_clr) begin
      m_clr = 0;
    end else if (m_ld) begin
      m_ld = 0; m_hold = 1; m_credit = 1;
    end else if (m_hold) begin
      m_hold = c;
    end else if (m_disp_left > 0) begin
      m_disp_left--;
      if (m_disp_left == 0) begin
        m_credit = 0;
        m_clr    = 1;
      end
    end else if (m_credit && !lt) begin
      m_disp_left = DISP_CYCLES;
      m_sold++;
    end else if (c) begin
      m_ld   = 1;
      m_idle = 0;
    end else if (m_credit) begin
      if (m_idle == TIMEOUT - 1) m_refund = 1;
      else m_idle++;
    end else begin
      m_idle = 0;
    end
  endtask

  task automatic compare();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("tot_ld",     32'(tot_ld),     32'(e[W-1]));
    check("tot_clr",    32'(tot_clr),    32'(e[W-2]));
    check("dispense",   32'(dispense),   32'(e[W-3]));
    check("refund",     32'(refund),     32'(e[W-4]));
    check("busy",       32'(busy),       32'(e[W-5]));
    check("vend_count", 32'(vend_count), 32'(e[CNT_W-1:0]));
    // Protocol-level monitors on the DUT's own outputs.
    if (tot_ld) ld_seen++;
    if (dispense) disp_run++;
    else if (disp_run > 0) begin
      if (!run_cut) check("disp_len", 32'(disp_run), 32'(DISP_CYCLES));
      disp_run = 0;
      run_cut  = 0;
    end
    if (prev_busy && !busy) wait_start = cyc;
    if (refund) begin
      refund_seen++;
      check("refund_lat", 32'(cyc - wait_start), 32'(TIMEOUT));
    end
    prev_busy = busy;
  endtask

  // Driver: lt_mode 0 = from datapath, 1 = force 1, 2 = force 0.
  task automatic step(input bit r, input bit c, input int lt_mode);
    bit lt;
    case (lt_mode)
      0:       lt = (total < price);
      1:       lt = 1'b1;
      default: lt = 1'b0;
    endcase
    rst_n    = r;
    coin_in  = c;
    tot_lt_s = lt;
    if (!r && disp_run > 0) run_cut = 1;
    if (m_clr || m_refund) total = 0;
    else if (m_ld) total += coin_val;
    model_advance(r, c, lt);
    exp_q.push_back(m_outputs());
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic idle(input int n, input int lt_mode);
    repeat (n) step(1, 0, lt_mode);
  endtask

  task automatic coin(input int hold, input int lt_mode);
    repeat (hold) step(1, 1, lt_mode);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ld0, rf0, n;
    bit  lvl;

    // Reset held for three cycles, then INIT clears the total once.
    repeat (3) step(0, 0, 1);
    idle(3, 1);
    check("rst_vend", 32'(vend_count), 0);
    check("rst_busy", 32'(busy), 0);

    // A coin held for five cycles loads exactly once and does not vend.
    price = 100; coin_val = 1;
    ld0 = ld_seen;
    coin(5, 0);
    idle(3, 0);
    check("held_coin_loads", 32'(ld_seen - ld0), 1);

    // Credit left idle: a second coin at idle cycle 150 restarts the refund timer.
    rf0 = refund_seen;
    idle(147, 0);
    check("no_early_refund", 32'(refund_seen - rf0), 0);
    coin(1, 0);
    idle(230, 0);
    check("refund_count", 32'(refund_seen - rf0), 1);

    // Three coins reach the price and trigger one vend.
    price = 3;
    repeat (3) begin
      coin(2, 0);
      idle(2, 0);
    end
    idle(10, 0);
    check("vend_after_three", 32'(vend_count), 1);

    // Coin and vend condition together: vend first, held coin reloads afterwards.
    price = 1;
    ld0 = ld_seen;
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    coin(12, 0);
    idle(12, 0);
    check("coin_through_vend_loads", 32'(ld_seen - ld0), 2);
    check("vend_after_reload", 32'(vend_count), 3);

    // Reset on the second dispense cycle aborts the vend and clears the count.
    step(1, 1, 0);
    n = 0;
    while (m_disp_left != DISP_CYCLES - 1 && n < 20) begin
      step(1, 0, 0);
      n++;
    end
    check("reach_disp2", 32'(m_disp_left == DISP_CYCLES - 1), 1);
    step(0, 0, 0);
    check("abort_dispense", 32'(dispense), 0);
    check("abort_vend", 32'(vend_count), 0);
    check("abort_busy", 32'(busy), 1);
    idle(3, 0);

    // Enough vends to saturate the counter.
    repeat (300) begin
      coin($urandom_range(1, 3), 0);
      idle(7 + $urandom_range(0, 3), 0);
    end
    check("vend_saturated", 32'(vend_count), 32'(VEND_MAX));

    // Random traffic with occasional resets, price changes and forced comparisons.
    lvl = 0;
    repeat (3000) begin
      bit r;
      int mode;
      if ($urandom_range(0, 9) < 3) lvl = ~lvl;
      if ($urandom_range(0, 49) == 0) price = $urandom_range(0, 4);
      coin_val = $urandom_range(1, 2);
      r = ($urandom_range(0, 299) != 0);
      mode = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      step(r, lvl, mode);
    end
    idle(5, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
